// File: rtl/reg_arb_pkg.sv
// ============================================================================
//  Module : reg_arb_pkg
//  Shared types and defaults for the two-port register bank arbiter.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package reg_arb_pkg;

    localparam int REG_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    typedef logic req_id_t;

endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
// ============================================================================
//  Module : rr_arb2
//  Two-way round-robin arbiter; the last-grant pointer moves only on i_adv.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_arb2
    import reg_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rstb,
    input  logic [1:0] i_req,
    input  logic       i_adv,
    output logic [1:0] o_gnt
);

    req_id_t r_last;

    // On a tie the port that was not granted last wins.
    always_comb begin
        o_gnt = 2'b00;
        if (i_req == 2'b11) begin
            o_gnt = r_last ? 2'b01 : 2'b10;
        end else begin
            o_gnt = i_req;
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_last <= 1'b1;
        end else if (i_adv && (o_gnt != 2'b00)) begin
            r_last <= o_gnt[1];
        end
    end

endmodule

`default_nettype wire

// File: rtl/reg_bank_arbiter.sv
// ============================================================================
//  Module : reg_bank_arbiter
//  Two-port config/status register bank with round-robin IDLE/ACCESS/RESP FSM.
//  Optional macro REG_LOCK_EN: MSB of the last config reg blocks m1 writes.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module reg_bank_arbiter
    import reg_arb_pkg::*;
#(
    parameter  int NUM_CFG    = 8,
    parameter  int NUM_STATUS = 8,
    parameter  int REG_WIDTH  = REG_WIDTH_DEFAULT,
    localparam int ADDR_W     = $clog2(NUM_CFG + NUM_STATUS)
) (
    input  logic                            clk,
    input  logic                            rstb,
    input  logic                            ena,
    input  logic                            m0_req,
    input  logic                            m0_we,
    input  logic [ADDR_W-1:0]               m0_addr,
    input  logic [REG_WIDTH-1:0]            m0_wdata,
    output logic                            m0_gnt,
    output logic                            m0_rvalid,
    output logic [REG_WIDTH-1:0]            m0_rdata,
    output logic                            m0_err,
    input  logic                            m1_req,
    input  logic                            m1_we,
    input  logic [ADDR_W-1:0]               m1_addr,
    input  logic [REG_WIDTH-1:0]            m1_wdata,
    output logic                            m1_gnt,
    output logic                            m1_rvalid,
    output logic [REG_WIDTH-1:0]            m1_rdata,
    output logic                            m1_err,
    output logic [NUM_CFG*REG_WIDTH-1:0]    config_regs,
    input  logic [NUM_STATUS*REG_WIDTH-1:0] status_regs,
    output logic                            busy
);

    arb_state_t             r_state;
    arb_state_t             w_state_nxt;
    logic                   w_start;

    logic [1:0]             w_req;
    logic [1:0]             w_arb_gnt;
    req_id_t                w_win_id;

    logic                   r_we;
    logic [ADDR_W-1:0]      r_addr;
    logic [REG_WIDTH-1:0]   r_wdata;
    req_id_t                r_id;
    logic [1:0]             r_gnt;
    logic [1:0]             r_rvalid;
    logic [REG_WIDTH-1:0]   r_rdata;
    logic                   r_err;
    logic [REG_WIDTH-1:0]   r_cfg    [NUM_CFG];

    logic [REG_WIDTH-1:0]   w_status [NUM_STATUS];
    logic [31:0]            w_addr_ext;
    logic                   w_is_cfg;
    logic                   w_is_stat;
    logic                   w_locked;
    logic [REG_WIDTH-1:0]   w_cfg_rd;
    logic [REG_WIDTH-1:0]   w_stat_rd;
    logic [REG_WIDTH-1:0]   w_rd;
    logic                   w_err;
    logic                   w_wr_ok;

    assign w_req = {m1_req, m0_req};

    rr_arb2 u_rr_arb2 (
        .clk   (clk),
        .rstb  (rstb),
        .i_req (w_req),
        .i_adv (w_start),
        .o_gnt (w_arb_gnt)
    );

    assign w_win_id = w_arb_gnt[1];

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        busy        = 1'b1;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (ena && (w_req != 2'b00)) begin
                    w_state_nxt = ACCESS;
                    w_start     = 1'b1;
                end
            end
            ACCESS:  w_state_nxt = RESP;
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Address decode and read mux
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_STATUS; gi++) begin : g_stat
            assign w_status[gi] = status_regs[gi*REG_WIDTH +: REG_WIDTH];
        end
        for (gi = 0; gi < NUM_CFG; gi++) begin : g_cfg
            assign config_regs[gi*REG_WIDTH +: REG_WIDTH] = r_cfg[gi];
        end
    endgenerate

    assign w_addr_ext = 32'(r_addr);
    assign w_is_cfg   = (w_addr_ext < 32'(NUM_CFG));
    assign w_is_stat  = !w_is_cfg && (w_addr_ext < 32'(NUM_CFG + NUM_STATUS));

`ifdef REG_LOCK_EN
    assign w_locked = r_cfg[NUM_CFG-1][REG_WIDTH-1] && (r_id == 1'b1);
`else
    assign w_locked = 1'b0;
`endif

    always_comb begin
        w_cfg_rd  = '0;
        w_stat_rd = '0;
        for (int i = 0; i < NUM_CFG; i++) begin
            if (w_addr_ext == 32'(i)) w_cfg_rd = r_cfg[i];
        end
        for (int i = 0; i < NUM_STATUS; i++) begin
            if (w_addr_ext == 32'(NUM_CFG + i)) w_stat_rd = w_status[i];
        end
    end

    // Writes always return zero data; unmapped reads return zero with err.
    assign w_rd    = r_we      ? '0        :
                     w_is_cfg  ? w_cfg_rd  :
                     w_is_stat ? w_stat_rd : '0;
    assign w_err   = !(w_is_cfg || w_is_stat)
                   || (r_we && w_is_stat)
                   || (r_we && w_is_cfg && w_locked);
    assign w_wr_ok = r_we && w_is_cfg && !w_locked;

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_id     <= 1'b0;
            r_gnt    <= 2'b00;
            r_rvalid <= 2'b00;
            r_rdata  <= '0;
            r_err    <= 1'b0;
            for (int i = 0; i < NUM_CFG; i++) r_cfg[i] <= '0;
        end else begin
            r_gnt    <= 2'b00;
            r_rvalid <= 2'b00;
            if (w_start) begin
                r_id    <= w_win_id;
                r_we    <= w_win_id ? m1_we    : m0_we;
                r_addr  <= w_win_id ? m1_addr  : m0_addr;
                r_wdata <= w_win_id ? m1_wdata : m0_wdata;
                r_gnt   <= w_arb_gnt;
            end
            if (r_state == ACCESS) begin
                r_rvalid <= r_id ? 2'b10 : 2'b01;
                r_rdata  <= w_rd;
                r_err    <= w_err;
                for (int i = 0; i < NUM_CFG; i++) begin
                    if (w_wr_ok && (w_addr_ext == 32'(i))) r_cfg[i] <= r_wdata;
                end
            end
            if (r_state == RESP) begin
                r_rdata <= '0;
                r_err   <= 1'b0;
            end
        end
    end

    assign m0_gnt    = r_gnt[0];
    assign m1_gnt    = r_gnt[1];
    assign m0_rvalid = r_rvalid[0];
    assign m1_rvalid = r_rvalid[1];
    assign m0_rdata  = r_rvalid[0] ? r_rdata : '0;
    assign m1_rdata  = r_rvalid[1] ? r_rdata : '0;
    assign m0_err    = r_rvalid[0] && r_err;
    assign m1_err    = r_rvalid[1] && r_err;

endmodule

`default_nettype wire

// File: tb/tb_reg_bank_arbiter.sv
// ============================================================================
//  Module : tb_reg_bank_arbiter
//  Scoreboard bench for reg_bank_arbiter (NUM_CFG=8, NUM_STATUS=4).
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_reg_bank_arbiter;

    logic        clk = 1'b0;
    logic        rstb;
    logic        ena;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [3:0]  m0_addr, m1_addr;
    logic [7:0]  m0_wdata, m1_wdata;
    logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
    logic [7:0]  m0_rdata, m1_rdata;
    logic [63:0] config_regs;
    logic [31:0] status_regs;
    logic        busy;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       port;
        logic [7:0] rd;
        logic       err;
    } exp_t;

    exp_t       sb [$];
    logic [7:0] exp_cfg [8];

    reg_bank_arbiter #(
        .NUM_CFG    (8),
        .NUM_STATUS (4),
        .REG_WIDTH  (8)
    ) dut (
        .clk         (clk),
        .rstb        (rstb),
        .ena         (ena),
        .m0_req      (m0_req),
        .m0_we       (m0_we),
        .m0_addr     (m0_addr),
        .m0_wdata    (m0_wdata),
        .m0_gnt      (m0_gnt),
        .m0_rvalid   (m0_rvalid),
        .m0_rdata    (m0_rdata),
        .m0_err      (m0_err),
        .m1_req      (m1_req),
        .m1_we       (m1_we),
        .m1_addr     (m1_addr),
        .m1_wdata    (m1_wdata),
        .m1_gnt      (m1_gnt),
        .m1_rvalid   (m1_rvalid),
        .m1_rdata    (m1_rdata),
        .m1_err      (m1_err),
        .config_regs (config_regs),
        .status_regs (status_regs),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] exp_flat();
        logic [63:0] f;
        for (int i = 0; i < 8; i++) f[i*8 +: 8] = exp_cfg[i];
        return f;
    endfunction

    // Response monitor: every rvalid pops one expected entry.
    always @(negedge clk) begin
        if (rstb && (m0_rvalid || m1_rvalid)) begin
            total++;
            if (m0_rvalid && m1_rvalid) begin
                bad++;
                $display("FAIL rvalid_both: m0=%0b m1=%0b, required only one", m0_rvalid, m1_rvalid);
            end else if (sb.size() == 0) begin
                bad++;
                $display("FAIL rvalid_unexpected: m0=%0b m1=%0b, required none", m0_rvalid, m1_rvalid);
            end else begin
                exp_t e;
                logic       ap;
                logic [7:0] ard;
                logic       aerr;
                e    = sb.pop_front();
                ap   = m1_rvalid;
                ard  = m1_rvalid ? m1_rdata : m0_rdata;
                aerr = m1_rvalid ? m1_err   : m0_err;
                if ({ap, ard, aerr} !== {e.port, e.rd, e.err}) begin
                    bad++;
                    $display("FAIL response: got port=%0d rdata=%02h err=%0b, required port=%0d rdata=%02h err=%0b",
                             ap, ard, aerr, e.port, e.rd, e.err);
                end
            end
        end
    end

    task automatic clear_inputs();
        m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstb = 1'b0;
        clear_inputs();
        for (int i = 0; i < 8; i++) exp_cfg[i] = 8'h00;
        sb.delete();
        repeat (2) @(negedge clk);
        rstb = 1'b1;
    endtask

    // One full transaction: request in IDLE, gnt next cycle, rvalid the cycle after.
    task automatic issue(input logic p, input logic we, input logic [3:0] addr,
                         input logic [7:0] wd, input logic [7:0] exp_rd, input logic exp_err);
        @(negedge clk);
        if (!p) begin m0_req = 1; m0_we = we; m0_addr = addr; m0_wdata = wd; end
        else    begin m1_req = 1; m1_we = we; m1_addr = addr; m1_wdata = wd; end
        sb.push_back('{port: p, rd: exp_rd, err: exp_err});
        if (we && !exp_err && addr < 4'd8) exp_cfg[addr[2:0]] = wd;
        @(negedge clk);
        total++;
        if ({m1_gnt, m0_gnt} !== (p ? 2'b10 : 2'b01) || busy !== 1'b1) begin
            bad++;
            $display("FAIL grant: gnt=%02b busy=%0b, required gnt=%02b busy=1",
                     {m1_gnt, m0_gnt}, busy, (p ? 2'b10 : 2'b01));
        end
        m0_req = 0; m1_req = 0;
        @(negedge clk);
        total++;
        if ((p ? m1_rvalid : m0_rvalid) !== 1'b1) begin
            bad++;
            $display("FAIL rvalid_timing: port%0d rvalid=%0b, required 1", p, (p ? m1_rvalid : m0_rvalid));
        end
        total++;
        if (config_regs !== exp_flat()) begin
            bad++;
            $display("FAIL config: got %016h, required %016h", config_regs, exp_flat());
        end
    endtask

    task automatic test_reset();
        rstb = 1'b0; ena = 1'b1; status_regs = 32'hE7_00_3C_00;
        clear_inputs();
        for (int i = 0; i < 8; i++) exp_cfg[i] = 8'h00;
        repeat (2) @(negedge clk);
        total++;
        if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err, busy} !== 7'b0 ||
            m0_rdata !== 8'h00 || m1_rdata !== 8'h00 || config_regs !== 64'h0) begin
            bad++;
            $display("FAIL reset_state: gnt=%0b%0b rv=%0b%0b err=%0b%0b busy=%0b cfg=%016h, required all 0",
                     m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err, busy, config_regs);
        end
        rstb = 1'b1;
    endtask

    task automatic test_write();
        issue(0, 1, 4'd2, 8'hA5, 8'h00, 0);
        total++;
        if (config_regs[23:16] !== 8'hA5) begin
            bad++;
            $display("FAIL write_reg2: got %02h, required a5", config_regs[23:16]);
        end
        issue(0, 0, 4'd2, 8'h00, 8'hA5, 0);
        issue(1, 0, 4'd2, 8'h00, 8'hA5, 0);
        issue(1, 1, 4'd7, 8'h3E, 8'h00, 0);
    endtask

    task automatic test_rr();
        logic g0, g1;
        do_reset();
        @(negedge clk);
        m0_req = 1; m0_we = 1; m0_addr = 4'd3; m0_wdata = 8'h11;
        m1_req = 1; m1_we = 1; m1_addr = 4'd4; m1_wdata = 8'h22;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            g0 = (k % 3 == 1) && (((k - 1) / 3) % 2 == 0);
            g1 = (k % 3 == 1) && (((k - 1) / 3) % 2 == 1);
            if (g0) begin sb.push_back('{port: 1'b0, rd: 8'h00, err: 1'b0}); exp_cfg[3] = 8'h11; end
            if (g1) begin sb.push_back('{port: 1'b1, rd: 8'h00, err: 1'b0}); exp_cfg[4] = 8'h22; end
            total++;
            if ({m1_gnt, m0_gnt} !== {g1, g0}) begin
                bad++;
                $display("FAIL rr_cycle%0d: gnt=%02b, required %02b", k, {m1_gnt, m0_gnt}, {g1, g0});
            end
        end
        @(negedge clk);
        m0_req = 0; m1_req = 0;
        total++;
        if (config_regs !== exp_flat()) begin
            bad++;
            $display("FAIL rr_config: got %016h, required %016h", config_regs, exp_flat());
        end
    endtask

    task automatic test_status();
        issue(1, 0, 4'd9, 8'h00, 8'h3C, 0);
        issue(1, 1, 4'd9, 8'h55, 8'h00, 1);
        issue(0, 0, 4'd8, 8'h00, 8'h00, 0);
        issue(0, 0, 4'd11, 8'h00, 8'hE7, 0);
    endtask

    task automatic test_oor();
        issue(0, 0, 4'd13, 8'h00, 8'h00, 1);
        issue(0, 1, 4'd13, 8'hFF, 8'h00, 1);
        issue(1, 0, 4'd12, 8'h00, 8'h00, 1);
        issue(1, 1, 4'd15, 8'h77, 8'h00, 1);
    endtask

    task automatic test_ena();
        @(negedge clk);
        ena = 0; m0_req = 1; m0_we = 0; m0_addr = 4'd3;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            total++;
            if (m0_gnt !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL ena_block%0d: gnt=%0b busy=%0b, required 0 0", k, m0_gnt, busy);
            end
        end
        ena = 1;
        sb.push_back('{port: 1'b0, rd: 8'h11, err: 1'b0});
        @(negedge clk);
        total++;
        if (m0_gnt !== 1'b1) begin
            bad++;
            $display("FAIL ena_release: gnt=%0b, required 1", m0_gnt);
        end
        m0_req = 0;
        @(negedge clk);
        @(negedge clk);
        m0_req = 1; m0_addr = 4'd4;
        sb.push_back('{port: 1'b0, rd: 8'h22, err: 1'b0});
        @(negedge clk);
        total++;
        if (m0_gnt !== 1'b1) begin
            bad++;
            $display("FAIL ena_drop_gnt: gnt=%0b, required 1", m0_gnt);
        end
        ena = 0; m0_req = 0;
        @(negedge clk);
        total++;
        if (m0_rvalid !== 1'b1) begin
            bad++;
            $display("FAIL ena_drop_resp: rvalid=%0b, required 1", m0_rvalid);
        end
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL ena_drop_idle: busy=%0b, required 0", busy);
        end
        ena = 1;
    endtask

    task automatic test_lock();
        issue(0, 1, 4'd7, 8'h80, 8'h00, 0);
`ifdef REG_LOCK_EN
        issue(1, 1, 4'd0, 8'h11, 8'h00, 1);
        issue(0, 1, 4'd0, 8'h44, 8'h00, 0);
        issue(0, 1, 4'd7, 8'h00, 8'h00, 0);
        issue(1, 1, 4'd0, 8'h11, 8'h00, 0);
`else
        issue(1, 1, 4'd0, 8'h11, 8'h00, 0);
        issue(1, 1, 4'd7, 8'h81, 8'h00, 0);
        issue(1, 0, 4'd7, 8'h00, 8'h81, 0);
`endif
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        m0_req = 1; m0_we = 1; m0_addr = 4'd5; m0_wdata = 8'h77;
        @(negedge clk);
        total++;
        if (m0_gnt !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_gnt: gnt=%0b, required 1", m0_gnt);
        end
        rstb = 0; m0_req = 0;
        for (int i = 0; i < 8; i++) exp_cfg[i] = 8'h00;
        #1;
        total++;
        if (busy !== 1'b0 || config_regs !== 64'h0 || m0_gnt !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_async: busy=%0b gnt=%0b cfg=%016h, required 0 0 0", busy, m0_gnt, config_regs);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++;
            if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0 || config_regs !== 64'h0) begin
                bad++;
                $display("FAIL rstmid_norv%0d: rv=%0b%0b cfg=%016h, required 0 0 0", k, m0_rvalid, m1_rvalid, config_regs);
            end
        end
        rstb = 1;
        issue(0, 0, 4'd5, 8'h00, 8'h00, 0);
        issue(1, 1, 4'd1, 8'h9C, 8'h00, 0);
    endtask

    initial begin
        test_reset();
        test_write();
        test_rr();
        test_status();
        test_oor();
        test_ena();
        test_lock();
        test_reset_mid();
        repeat (3) @(negedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_drain: %0d responses outstanding, required 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
